// File: rtl/morse_key_decoder.sv
// Morse key front end: times debounced key presses, classifies them as dots
// or dashes, and after five symbols decodes the pattern to a digit 0-9 with
// a one-cycle load pulse. Invalid patterns and abandoned entries pulse error.
//
// state  | meaning
// -------+---------------------------------------------------------------
// ARM    | waiting for key released so a held key is never counted
// IDLE   | key up; waiting for a press, timing the gap between symbols
// PRESS  | key down; timing the press length
// DECODE | five symbols captured; translate pattern to digit for one cycle
module morse_key_decoder #(
  parameter int MIN_CYCLES  = 2_500_000,
  parameter int DASH_CYCLES = 15_000_000,
  parameter int GAP_CYCLES  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       key,
  output logic [3:0] user_input,
  output logic       load,
  output logic       error,
  output logic [2:0] sym_count,
  output logic [4:0] pattern
);

  localparam int CNT_MAX = (DASH_CYCLES > GAP_CYCLES) ? DASH_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] MIN_C    = CW'(MIN_CYCLES);
  localparam logic [CW-1:0] DASH_C   = CW'(DASH_CYCLES);
  // Timeout fires on the edge where the gap count would reach GAP_CYCLES.
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ARM    = 2'd0,
    IDLE   = 2'd1,
    PRESS  = 2'd2,
    DECODE = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] press_cnt, press_cnt_n;
  logic [CW-1:0] gap_cnt, gap_cnt_n;
  logic [4:0]    pattern_n;
  logic [2:0]    sym_count_n;
  logic [3:0]    user_input_n;
  logic          load_n, error_n;

  // Returns {match, digit}; dot=0, dash=1, oldest symbol in bit 4.
  function automatic logic [4:0] decode_pattern(input logic [4:0] p);
    logic [4:0] r;
    r = 5'b0_0000;
    case (p)
      5'b01111: r = {1'b1, 4'd1};
      5'b00111: r = {1'b1, 4'd2};
      5'b00011: r = {1'b1, 4'd3};
      5'b00001: r = {1'b1, 4'd4};
      5'b00000: r = {1'b1, 4'd5};
      5'b10000: r = {1'b1, 4'd6};
      5'b11000: r = {1'b1, 4'd7};
      5'b11100: r = {1'b1, 4'd8};
      5'b11110: r = {1'b1, 4'd9};
      5'b11111: r = {1'b1, 4'd0};
      default:  r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // State and datapath registers; everything clears on async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARM;
      press_cnt  <= '0;
      gap_cnt    <= '0;
      pattern    <= '0;
      sym_count  <= '0;
      user_input <= '0;
      load       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      press_cnt  <= press_cnt_n;
      gap_cnt    <= gap_cnt_n;
      pattern    <= pattern_n;
      sym_count  <= sym_count_n;
      user_input <= user_input_n;
      load       <= load_n;
      error      <= error_n;
    end
  end

  // Next-state, counter and output-pulse logic.
  always_comb begin
    logic [4:0] dec;
    state_n      = state;
    press_cnt_n  = press_cnt;
    gap_cnt_n    = gap_cnt;
    pattern_n    = pattern;
    sym_count_n  = sym_count;
    user_input_n = user_input;
    load_n       = 1'b0;
    error_n      = 1'b0;
    dec          = decode_pattern(pattern);

    if (!enable) begin
      // Dropping enable abandons any partial entry, including one in DECODE.
      state_n     = ARM;
      press_cnt_n = '0;
      gap_cnt_n   = '0;
      pattern_n   = '0;
      sym_count_n = '0;
    end else begin
      case (state)
        ARM: begin
          if (!key) state_n = IDLE;
        end

        IDLE: begin
          if (key) begin
            // A press beats a coincident gap timeout; the gap is not counted.
            state_n     = PRESS;
            press_cnt_n = {{(CW-1){1'b0}}, 1'b1};
          end else if (sym_count != 3'd0) begin
            if (gap_cnt >= GAP_LAST) begin
              error_n     = 1'b1;
              pattern_n   = '0;
              sym_count_n = '0;
              gap_cnt_n   = '0;
            end else begin
              gap_cnt_n = gap_cnt + 1'b1;
            end
          end
        end

        PRESS: begin
          if (key) begin
            if (press_cnt < DASH_C) press_cnt_n = press_cnt + 1'b1;
          end else if (press_cnt < MIN_C) begin
            // Glitch: dropped without disturbing the running gap count.
            state_n = IDLE;
          end else begin
            pattern_n = {pattern[3:0], (press_cnt >= DASH_C)};
            gap_cnt_n = '0;
            if (sym_count == 3'd4) begin
              // sym_count stays at 4 for the single DECODE cycle.
              state_n = DECODE;
            end else begin
              sym_count_n = sym_count + 3'd1;
              state_n     = IDLE;
            end
          end
        end

        DECODE: begin
          if (dec[4]) begin
            user_input_n = dec[3:0];
            load_n       = 1'b1;
          end else begin
            error_n = 1'b1;
          end
          pattern_n   = '0;
          sym_count_n = '0;
          state_n     = ARM;
        end

        default: state_n = ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Scoreboard bench for morse_key_decoder with small timing parameters.
module tb_morse_key_decoder;

  localparam int MIN_C  = 2;
  localparam int DASH_C = 6;
  localparam int GAP_C  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       key = 1'b0;
  logic [3:0] user_input;
  logic       load, error;
  logic [2:0] sym_count;
  logic [4:0] pattern;

  morse_key_decoder #(
    .MIN_CYCLES (MIN_C),
    .DASH_CYCLES(DASH_C),
    .GAP_CYCLES (GAP_C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .key       (key),
    .user_input(user_input),
    .load      (load),
    .error     (error),
    .sym_count (sym_count),
    .pattern   (pattern)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_err;
    int       digit;
    int       when;   // cycle the pulse must appear in, -1 = any
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   prev_pulse = 0;

  // Reference model: symbols accepted so far and the digit table.
  bit   syms[$];
  int   last_digit = 0;
  logic [4:0] pat_of [10] = '{5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
                              5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110};

  always @(posedge clk) cyc++;

  // Monitor: every load/error pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && (load || error)) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: load=%0b error=%0b at cycle %0d, none expected",
                 load, error, cyc);
      end else begin
        e = q.pop_front();
        if ((load && error) || prev_pulse || (error != e.is_err) ||
            (!e.is_err && user_input != e.digit[3:0]) ||
            (e.when >= 0 && e.when != cyc)) begin
          miscompares++;
          $display("FAIL pulse: got load=%0b error=%0b digit=%0d cycle=%0d prev=%0b, expected err=%0b digit=%0d cycle=%0d",
                   load, error, user_input, cyc, prev_pulse, e.is_err, e.digit, e.when);
        end
      end
    end
    prev_pulse = rst && (load || error);
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a release of an n-cycle press at the coming edge.
  task automatic model_release(input int n);
    int v;
    bit ok;
    int d;
    if (n < MIN_C) return;
    syms.push_back(n >= DASH_C);
    if (syms.size() == 5) begin
      v = 0;
      for (int i = 0; i < 5; i++) v = v * 2 + int'(syms[i]);
      ok = 0;
      d = 0;
      for (int k = 0; k < 10; k++) if (int'(pat_of[k]) == v) begin ok = 1; d = k; end
      if (ok) last_digit = d;
      q.push_back('{is_err: !ok, digit: d, when: cyc + 2});
      syms.delete();
    end
  endtask

  // Called at a negedge: key high for n edges, then low for gap edges.
  task automatic press(input int n, input int gap);
    key = 1'b1;
    repeat (n) @(negedge clk);
    key = 1'b0;
    model_release(n);
    repeat (gap) @(negedge clk);
  endtask

  task automatic entry(input logic [4:0] p);
    for (int i = 0; i < 5; i++) begin
      if ($urandom_range(0, 5) == 0) press(1, $urandom_range(2, 4));
      press(p[4-i] ? $urandom_range(DASH_C, 12) : $urandom_range(MIN_C, DASH_C - 1),
            (i == 4) ? $urandom_range(4, 6) : $urandom_range(2, 5));
    end
  endtask

  initial begin
    int budget;
    // Reset values.
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_user_input", user_input, 0);
    check("rst_load_error", {load, error}, 0);
    check("rst_sym_count", sym_count, 0);
    check("rst_pattern", pattern, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // .---- -> 1
    press(3, 4); press(8, 4); press(8, 4); press(8, 4);
    check("partial_pattern", pattern, 5'b00111);
    check("partial_sym_count", sym_count, 4);
    press(8, 4);
    check("digit_1", user_input, 1);

    // ----- -> 0, then ..-.. -> error, user_input held
    for (int i = 0; i < 5; i++) press(10, (i == 4) ? 4 : 3);
    check("digit_0", user_input, 0);
    press(3, 3); press(3, 3); press(8, 3); press(3, 3); press(3, 5);
    check("invalid_holds_digit", user_input, 0);

    // Glitch between two dots; press-length boundaries 2 (dot) and 5 (dot)
    press(MIN_C, 3); press(5, 3); press(1, 3);
    check("glitch_sym_count", sym_count, 2);
    check("glitch_pattern", pattern, 5'b00000);
    press(3, 3); press(3, 3); press(3, 5);
    check("digit_5", user_input, 5);

    // Dash boundary: exactly DASH_C cycles is a dash (----. would be 9)
    press(DASH_C, 3); press(DASH_C, 3); press(DASH_C, 3); press(DASH_C, 3); press(3, 5);
    check("digit_9", user_input, 9);

    // Gap timeout
    press(3, 3); press(3, 0);
    q.push_back('{is_err: 1, digit: 0, when: -1});
    syms.delete();
    repeat (25) @(negedge clk);
    check("timeout_sym_count", sym_count, 0);
    check("timeout_pattern", pattern, 0);
    entry(pat_of[7]);
    check("after_timeout_digit", user_input, 7);

    // Key held at enable rise, then enable dropped mid-entry
    enable = 1'b0;
    key = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (8) @(negedge clk);
    key = 1'b0;
    repeat (3) @(negedge clk);
    check("held_key_ignored", sym_count, 0);
    press(3, 2); press(3, 2); press(8, 2);
    check("three_symbols", sym_count, 3);
    enable = 1'b0;
    @(negedge clk);
    check("disable_clears_count", sym_count, 0);
    check("disable_clears_pattern", pattern, 0);
    syms.delete();
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized entries, mostly valid digits, some arbitrary patterns
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) entry(5'($urandom_range(0, 31)));
      else entry(pat_of[$urandom_range(0, 9)]);
      check("model_digit", user_input, last_digit);
    end

    // Async reset mid-press with four symbols captured
    press(3, 2); press(8, 2); press(3, 2); press(8, 2);
    check("pre_reset_count", sym_count, 4);
    key = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_user_input", user_input, 0);
    check("async_sym_count", sym_count, 0);
    check("async_pattern", pattern, 0);
    check("async_load_error", {load, error}, 0);
    syms.delete();
    last_digit = 0;
    @(negedge clk);
    key = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    entry(pat_of[3]);
    check("post_reset_digit", user_input, 3);

    // Drain scoreboard with a bounded wait.
    budget = 200;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
